posit_ext_sched: RTL and testbench

//  Operand packer/scheduler in front of the multi-precision posit extraction unit.

---
 rtl/posit_ext_sched.sv | 174 +++++++++++++++++
 tb/tb_posit_ext_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_ext_sched.sv
// Operand packer/scheduler: packs consecutive same-precision posit operands into one
// 32-bit SIMD word (4xP8, 2xP16 or 1xP32) with a lane mask and tags for the extraction unit.
module posit_ext_sched #(
    parameter int unsigned TIMEOUT = 4,
    parameter int unsigned TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [1:0]         out_mode,
    output logic [3:0]         out_lane_vld,
    output logic [4*TAG_W-1:0] out_tags,
    output logic               err_illegal,
    output logic               busy
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned TAGS_W = LANES * TAG_W;
    localparam int unsigned TMO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [1:0] MODE_P8  = 2'b00;
    localparam logic [1:0] MODE_P16 = 2'b01;
    localparam logic [1:0] MODE_P32 = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_SEND} state_e;

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [LANES-1:0]    vld_q, vld_d;
    logic [TAGS_W-1:0]   tags_q, tags_d;
    logic [2:0]          lanes_q, lanes_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_q, err_d;
    logic                wr_en;
    logic [2:0]          cap;
    logic [2:0]          lanes_inc;

    // In FILL only the latched precision (or an illegal code, which is dropped) may enter
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_FILL:  in_ready = (in_mode == mode_q) || (in_mode == MODE_ILL);
            default: in_ready = 1'b0;
        endcase
        if (!rst_n) in_ready = 1'b0;
    end

    always_comb begin
        unique case (mode_q)
            MODE_P8:  cap = 3'd4;
            MODE_P16: cap = 3'd2;
            default:  cap = 3'd1;
        endcase
    end

    assign lanes_inc = lanes_q + 3'd1;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        vld_d   = vld_q;
        tags_d  = tags_q;
        lanes_d = lanes_q;
        tmo_d   = tmo_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_mode == MODE_ILL) begin
                    err_d = 1'b1;
                end else if (in_valid) begin
                    wr_en   = 1'b1;
                    mode_d  = in_mode;
                    lanes_d = 3'd1;
                    tmo_d   = '0;
                    state_d = (in_mode == MODE_P32) ? S_SEND : S_FILL;
                end
            end
            S_FILL: begin
                if (in_valid && in_mode == MODE_ILL) begin
                    err_d = 1'b1;
                    if (flush) state_d = S_SEND;
                end else if (in_valid && in_mode == mode_q) begin
                    wr_en   = 1'b1;
                    lanes_d = lanes_inc;
                    tmo_d   = '0;
                    if (lanes_inc == cap || flush) state_d = S_SEND;
                end else if (in_valid || flush) begin
                    state_d = S_SEND;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = S_SEND;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    mode_d  = '0;
                    data_d  = '0;
                    vld_d   = '0;
                    tags_d  = '0;
                    lanes_d = '0;
                    tmo_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Lane placement: slot index is the number of operands already in the word
        if (wr_en) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (lanes_q == 3'(k)) begin
                    tags_d[k*TAG_W +: TAG_W] = in_tag;
                    if (in_mode == MODE_P8) begin
                        data_d[8*k +: 8] = in_data[7:0];
                        vld_d[k]         = 1'b1;
                    end else if (in_mode == MODE_P16) begin
                        data_d[16*(k%2) +: 16] = in_data[15:0];
                        vld_d[2*(k%2) +: 2]    = 2'b11;
                    end
                end
            end
            if (in_mode == MODE_P32) begin
                data_d = in_data;
                vld_d  = 4'b1111;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            data_q  <= '0;
            vld_q   <= '0;
            tags_q  <= '0;
            lanes_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            tags_q  <= tags_d;
            lanes_q <= lanes_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign out_valid    = (state_q == S_SEND);
    assign out_data     = data_q;
    assign out_mode     = mode_q;
    assign out_lane_vld = vld_q;
    assign out_tags     = tags_q;
    assign err_illegal  = err_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_posit_ext_sched.sv
// Bench for posit_ext_sched: directed scenarios plus a randomized operand stream
// checked against a word-grouping reference model.
module tb_posit_ext_sched;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned NOPS    = 60;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_data;
    logic [1:0]         in_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic [1:0]         out_mode;
    logic [3:0]         out_lane_vld;
    logic [4*TAG_W-1:0] out_tags;
    logic               err_illegal;
    logic               busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  mode;
        logic [3:0]  vld;
        logic [15:0] tags;
    } word_t;

    always #5 clk = ~clk;

    posit_ext_sched #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode), .out_lane_vld(out_lane_vld), .out_tags(out_tags),
        .err_illegal(err_illegal), .busy(busy)
    );

    // Present one operand for a cycle; caller guarantees it will be accepted
    task automatic send_op(input logic [1:0] m, input logic [31:0] d, input logic [3:0] t);
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_tag   = t;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_mode, out_lane_vld, out_tags, err_illegal, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h m=%b l=%b t=%h e=%b b=%b want all 0",
                     out_valid, out_data, out_mode, out_lane_vld, out_tags, err_illegal, busy);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL idle_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_p8_pack();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_op(2'b00, 32'hFFFFFF00 | 32'(8'h11 * (i + 1)), 4'(i + 1));
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL p8_partial: got v=%b b=%b want v=0 b=1", out_valid, busy);
        end
        send_op(2'b00, 32'hABCDEF44, 4'd4);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_data, out_mode, out_lane_vld, out_tags} !== {1'b1, 32'h44332211, 2'b00, 4'b1111, 16'h4321}) begin
            errors++;
            $display("FAIL p8_word: got v=%b d=%h m=%b l=%b t=%h want v=1 d=44332211 m=00 l=1111 t=4321",
                     out_valid, out_data, out_mode, out_lane_vld, out_tags);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL send_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
            errors++; $display("FAIL p8_drain: got v=%b b=%b d=%h want 0 0 0", out_valid, busy, out_data);
        end
    endtask

    task automatic test_timeout();
        out_ready = 1'b1;
        send_op(2'b00, 32'h11, 4'd1);
        send_op(2'b00, 32'h22, 4'd2);
        send_op(2'b00, 32'h33, 4'd3);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (TIMEOUT - 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL timeout_early: got v=%b b=%b want v=0 b=1", out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_mode, out_lane_vld, out_tags} !== {1'b1, 32'h00332211, 2'b00, 4'b0111, 16'h0321}) begin
            errors++;
            $display("FAIL timeout_word: got v=%b d=%h m=%b l=%b t=%h want v=1 d=00332211 m=00 l=0111 t=0321",
                     out_valid, out_data, out_mode, out_lane_vld, out_tags);
        end
        @(negedge clk);
    endtask

    task automatic test_mode_switch();
        out_ready = 1'b0;
        send_op(2'b01, 32'h1234ABCD, 4'd5);
        @(negedge clk);
        in_valid = 1'b1; in_mode = 2'b00; in_data = 32'h5A; in_tag = 4'd6;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL switch_hold: got in_ready=%b want 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_mode, out_lane_vld, out_tags} !== {1'b1, 32'h0000ABCD, 2'b01, 4'b0011, 16'h0005}) begin
            errors++;
            $display("FAIL switch_p16_word: got v=%b d=%h m=%b l=%b t=%h want v=1 d=0000abcd m=01 l=0011 t=0005",
                     out_valid, out_data, out_mode, out_lane_vld, out_tags);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL switch_reaccept: got in_ready=%b v=%b want 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if ({out_valid, out_data, out_mode, out_lane_vld, out_tags} !== {1'b1, 32'h0000005A, 2'b00, 4'b0001, 16'h0006}) begin
            errors++;
            $display("FAIL switch_p8_word: got v=%b d=%h m=%b l=%b t=%h want v=1 d=0000005a m=00 l=0001 t=0006",
                     out_valid, out_data, out_mode, out_lane_vld, out_tags);
        end
        @(negedge clk);
    endtask

    task automatic test_p32_stall();
        logic [54:0] first;
        out_ready = 1'b0;
        send_op(2'b10, 32'hDEADBEEF, 4'hA);
        @(negedge clk);
        in_valid = 1'b0;
        first = {out_data, out_mode, out_lane_vld, out_tags, out_valid};
        checks++;
        if (first !== {32'hDEADBEEF, 2'b10, 4'b1111, 16'h000A, 1'b1}) begin
            errors++;
            $display("FAIL p32_word: got d=%h m=%b l=%b t=%h v=%b want d=deadbeef m=10 l=1111 t=000a v=1",
                     out_data, out_mode, out_lane_vld, out_tags, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({out_data, out_mode, out_lane_vld, out_tags, out_valid} !== {32'hDEADBEEF, 2'b10, 4'b1111, 16'h000A, 1'b1}) begin
                errors++; $display("FAIL p32_hold: cycle %0d got d=%h v=%b want d=deadbeef v=1", i, out_data, out_valid);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL p32_release: got v=%b b=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        send_op(2'b00, 32'h77, 4'd2);
        @(negedge clk);
        in_valid = 1'b1; in_mode = 2'b11; in_data = 32'h99; in_tag = 4'd9;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL illegal_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (err_illegal !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL illegal_pulse: got e=%b b=%b v=%b want 1 1 0", err_illegal, busy, out_valid);
        end
        send_op(2'b00, 32'h88, 4'd3);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        checks++;
        if (err_illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_oneshot: got e=%b want 0", err_illegal);
        end
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if ({out_valid, out_data, out_mode, out_lane_vld, out_tags} !== {1'b1, 32'h00008877, 2'b00, 4'b0011, 16'h0032}) begin
            errors++;
            $display("FAIL illegal_word: got v=%b d=%h m=%b l=%b t=%h want v=1 d=00008877 m=00 l=0011 t=0032",
                     out_valid, out_data, out_mode, out_lane_vld, out_tags);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_flush: got b=%b v=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset_send();
        bit seen;
        out_ready = 1'b0;
        send_op(2'b10, 32'hCAFEF00D, 4'd7);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_send: got v=%b r=%b b=%b want 0 0 0", out_valid, in_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL reset_discard: got word after reset, want none");
        end
    endtask

    task automatic test_random();
        logic [31:0] op_d [NOPS];
        logic [1:0]  op_m [NOPS];
        logic [3:0]  op_t [NOPS];
        word_t       exp_q[$];
        word_t       cur, got, want;
        int          lanes, cap, idx, cyc, words;
        bit          acc;

        // Reference model: runs of equal precision, chopped at the lane capacity
        for (int i = 0; i < NOPS; i++) begin
            op_d[i] = $urandom;
            op_t[i] = 4'($urandom_range(0, 15));
            if (i == 0 || $urandom_range(0, 3) == 0) op_m[i] = 2'($urandom_range(0, 2));
            else op_m[i] = op_m[i-1];
        end
        lanes = 0; cap = 0;
        cur = '{data: 32'h0, mode: 2'b00, vld: 4'h0, tags: 16'h0};
        for (int i = 0; i < NOPS; i++) begin
            if (lanes > 0 && (op_m[i] != cur.mode || lanes == cap)) begin
                exp_q.push_back(cur);
                lanes = 0;
                cur = '{data: 32'h0, mode: 2'b00, vld: 4'h0, tags: 16'h0};
            end
            cur.mode = op_m[i];
            cap = (op_m[i] == 2'b00) ? 4 : (op_m[i] == 2'b01) ? 2 : 1;
            cur.tags = cur.tags | (16'(op_t[i]) << (4 * lanes));
            if (op_m[i] == 2'b00) begin
                cur.data = cur.data | ((op_d[i] % 256) << (8 * lanes));
                cur.vld  = cur.vld | 4'(1 << lanes);
            end else if (op_m[i] == 2'b01) begin
                cur.data = cur.data | ((op_d[i] % 65536) << (16 * lanes));
                cur.vld  = cur.vld | 4'(3 << (2 * lanes));
            end else begin
                cur.data = op_d[i];
                cur.vld  = 4'hF;
            end
            lanes++;
        end
        if (lanes > 0) exp_q.push_back(cur);
        words = exp_q.size();

        idx = 0; cyc = 0;
        while ((idx < NOPS || exp_q.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid  = (idx < NOPS);
            if (idx < NOPS) begin
                in_data = op_d[idx]; in_mode = op_m[idx]; in_tag = op_t[idx];
            end
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                got = '{data: out_data, mode: out_mode, vld: out_lane_vld, tags: out_tags};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra: unexpected word d=%h m=%b", out_data, out_mode);
                end else begin
                    want = exp_q.pop_front();
                    if ({got.data, got.mode, got.vld, got.tags} !== {want.data, want.mode, want.vld, want.tags}) begin
                        errors++;
                        $display("FAIL rand_word: got d=%h m=%b l=%b t=%h want d=%h m=%b l=%b t=%h",
                                 got.data, got.mode, got.vld, got.tags, want.data, want.mode, want.vld, want.tags);
                    end
                end
            end
            @(posedge clk);
            if (acc) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0 || idx != NOPS) begin
            errors++;
            $display("FAIL rand_drain: got %0d words left, %0d ops sent, want 0 left of %0d, %0d sent",
                     exp_q.size(), idx, words, NOPS);
        end
    endtask

    initial begin
        test_reset();
        test_p8_pack();
        test_timeout();
        test_mode_switch();
        test_p32_stall();
        test_illegal();
        test_reset_send();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
